// File: rtl/muldiv_issue_ctrl_pkg.sv
// Shared encodings and latency defaults for the HI/LO multiply/divide unit
// and the E-stage issue controller that sequences it.
package muldiv_issue_ctrl_pkg;

  // E-stage muldiv-class instruction encodings (req_op)
  typedef enum logic [2:0] {
    OP_MULTU = 3'b000,
    OP_MULT  = 3'b001,
    OP_DIVU  = 3'b010,
    OP_DIV   = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFHI  = 3'b110,
    OP_MFLO  = 3'b111
  } req_op_e;

  // Unit MulOp control values
  localparam logic [2:0] MULOP_MULTU = 3'b000;
  localparam logic [2:0] MULOP_MULT  = 3'b001;
  localparam logic [2:0] MULOP_DIVU  = 3'b010;
  localparam logic [2:0] MULOP_DIV   = 3'b011;
  localparam logic [2:0] MULOP_NONE  = 3'b111;

  // Unit MTHILO control values
  localparam logic [1:0] MT_LO   = 2'b00;
  localparam logic [1:0] MT_HI   = 2'b01;
  localparam logic [1:0] MT_NONE = 2'b11;

  // Busy latencies shared by the unit and the controller
  localparam int MUL_LAT_DFLT = 5;
  localparam int DIV_LAT_DFLT = 10;
  localparam int CNT_W_DFLT   = 4;

  // Instruction class as seen by the issue logic
  typedef enum logic [1:0] {
    CLS_MUL = 2'b00,
    CLS_DIV = 2'b01,
    CLS_MT  = 2'b10,
    CLS_MF  = 2'b11
  } op_class_e;

  // Controller occupancy states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN_MUL = 2'b01,
    ST_RUN_DIV = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_issue_ctrl_decode.sv
// Combinational req_op decoder: class, raw MulOp, raw MTHILO and HI/LO read
// select. Ungated, so the D-stage hazard unit can reuse it unchanged.
module muldiv_decode
  import muldiv_issue_ctrl_pkg::*;
(
  input  logic [2:0] op_i,
  output op_class_e  cls_o,
  output logic [2:0] mul_op_o,
  output logic [1:0] mthilo_o,
  output logic       hilo_sel_o
);

  // Map each opcode to its class and raw unit controls
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    cls_o      = CLS_MF;
    mul_op_o   = MULOP_NONE;
    mthilo_o   = MT_NONE;
    hilo_sel_o = (op_i == OP_MFHI);
    unique case (op_i)
      OP_MULTU: begin cls_o = CLS_MUL; mul_op_o = MULOP_MULTU; end
      OP_MULT:  begin cls_o = CLS_MUL; mul_op_o = MULOP_MULT;  end
      OP_DIVU:  begin cls_o = CLS_DIV; mul_op_o = MULOP_DIVU;  end
      OP_DIV:   begin cls_o = CLS_DIV; mul_op_o = MULOP_DIV;   end
      OP_MTHI:  begin cls_o = CLS_MT;  mthilo_o = MT_HI;       end
      OP_MTLO:  begin cls_o = CLS_MT;  mthilo_o = MT_LO;       end
      default:  cls_o = CLS_MF;
    endcase
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// E-stage issue controller for the shared HI/LO multiply/divide unit.
// Models unit occupancy with a latency counter, stalls D/E while an
// operation is in flight and flags any divergence from the unit's busy.
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DFLT,
  parameter int DIV_LAT = DIV_LAT_DFLT,
  parameter int CNT_W   = CNT_W_DFLT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  input  logic       flush,
  input  logic       unit_busy,
  output logic [2:0] mul_op,
  output logic [1:0] mthilo,
  output logic       hilo_sel,
  output logic       stall,
  output logic       busy,
  output logic       sync_err
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_err_q, sync_err_d;

  op_class_e        dec_cls;
  logic [2:0]       dec_mul_op;
  logic [1:0]       dec_mthilo;
  logic             dec_hilo_sel;
  logic             live_req;
  logic             go;

  muldiv_decode u_decode (
    .op_i       (req_op),
    .cls_o      (dec_cls),
    .mul_op_o   (dec_mul_op),
    .mthilo_o   (dec_mthilo),
    .hilo_sel_o (dec_hilo_sel)
  );

  // Flush wins over everything: a killed request neither stalls nor issues.
  // Every muldiv-class op waits on busy, which keeps HI/LO accesses ordered.
  assign live_req = req_valid & ~flush;
  assign busy     = (state_q != ST_IDLE);
  assign stall    = live_req & busy;
  assign go       = live_req & ~busy;
  assign mul_op   = go ? dec_mul_op : MULOP_NONE;
  assign mthilo   = go ? dec_mthilo : MT_NONE;
  assign hilo_sel = dec_hilo_sel;
  assign sync_err = sync_err_q;

  // Next state: start a run on mul/div issue, count down to IDLE
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = sync_err_q | (busy != unit_busy);
    unique case (state_q)
      ST_IDLE: begin
        if (go && dec_cls == CLS_MUL) begin
          state_d = ST_RUN_MUL;
          cnt_d   = CNT_W'(MUL_LAT);
        end else if (go && dec_cls == CLS_DIV) begin
          state_d = ST_RUN_DIV;
          cnt_d   = CNT_W'(DIV_LAT);
        end
      end
      ST_RUN_MUL, ST_RUN_DIV: begin
        // Flush does not abort a run; the counter never wraps below zero.
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and sticky error registers with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed self-checking bench for muldiv_issue_ctrl with a behavioural
// HI/LO multiply/divide unit attached to its MulOp/MTHILO outputs.
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset, req_valid, flush, unit_busy;
  logic [2:0]  req_op, mul_op;
  logic [1:0]  mthilo;
  logic        hilo_sel, stall, busy, sync_err;

  // Behavioural unit state
  logic [31:0] opa, opb, hi, lo, p_hi, p_lo, rd_val;
  logic [3:0]  ucnt;
  logic        force_idle;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  muldiv_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .flush     (flush),
    .unit_busy (unit_busy),
    .mul_op    (mul_op),
    .mthilo    (mthilo),
    .hilo_sel  (hilo_sel),
    .stall     (stall),
    .busy      (busy),
    .sync_err  (sync_err)
  );

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    longint x, y;
    x = longint'($signed(a));
    y = longint'($signed(b));
    return 64'(x * y);
  endfunction

  function automatic logic [31:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return 32'(x / y);
  endfunction

  function automatic logic [31:0] srem(input logic [31:0] a, input logic [31:0] b);
    int x, y;
    x = $signed(a);
    y = $signed(b);
    return 32'(x % y);
  endfunction

  // Multiply/divide unit: busy for the latency, results land as busy drops
  always @(posedge clk) begin
    if (reset) begin
      ucnt <= 4'd0;
    end else begin
      if (ucnt != 4'd0) begin
        ucnt <= ucnt - 4'd1;
        if (ucnt == 4'd1) begin
          hi <= p_hi;
          lo <= p_lo;
        end
      end
      case (mul_op)
        3'b000: begin ucnt <= 4'(MUL_LAT_DFLT); {p_hi, p_lo} <= {32'd0, opa} * {32'd0, opb}; end
        3'b001: begin ucnt <= 4'(MUL_LAT_DFLT); {p_hi, p_lo} <= smul(opa, opb); end
        3'b010: begin ucnt <= 4'(DIV_LAT_DFLT); p_lo <= opa / opb; p_hi <= opa % opb; end
        3'b011: begin ucnt <= 4'(DIV_LAT_DFLT); p_lo <= sdiv(opa, opb); p_hi <= srem(opa, opb); end
        default: ;
      endcase
      if (mthilo == 2'b01) hi <= opa;
      else if (mthilo == 2'b00) lo <= opa;
    end
  end

  assign unit_busy = (ucnt != 4'd0) & ~force_idle;
  assign rd_val    = hilo_sel ? hi : lo;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; flush = 1'b0; req_op = OP_MULTU;
    opa = 32'd0; opb = 32'd1; force_idle = 1'b0;
    tick(); tick();
    #1;
    vectors++; if (mul_op !== 3'b111) begin miscompares++; $display("FAIL reset_mul_op got %b want 111", mul_op); end
    vectors++; if (mthilo !== 2'b11) begin miscompares++; $display("FAIL reset_mthilo got %b want 11", mthilo); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall got %b want 0", stall); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (hilo_sel !== 1'b0) begin miscompares++; $display("FAIL reset_hilo_sel got %b want 0", hilo_sel); end
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL reset_sync_err got %b want 0", sync_err); end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    req_valid = 1'b1; req_op = OP_MULT; opa = 32'd6; opb = 32'hFFFF_FFF9;  // 6 * -7
    #1;
    vectors++; if (mul_op !== 3'b001) begin miscompares++; $display("FAIL mult_issue_mul_op got %b want 001", mul_op); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mult_issue_stall got %b want 0", stall); end
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) req_valid = 1'b0;
      #1;
      vectors++;
      if (busy !== (i <= 5)) begin miscompares++; $display("FAIL mult_busy cyc%0d got %b want %b", i, busy, (i <= 5)); end
    end
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL mult_sync_err got %b want 0", sync_err); end
    req_valid = 1'b1; req_op = OP_MFLO;
    #1;
    vectors++; if (rd_val !== 32'hFFFF_FFD6) begin miscompares++; $display("FAIL mult_lo got %h want ffffffd6", rd_val); end
    tick();
    req_op = OP_MFHI;
    #1;
    vectors++; if (rd_val !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi got %h want ffffffff", rd_val); end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    req_valid = 1'b1; req_op = OP_MULTU; opa = 32'd3; opb = 32'd4;
    tick();
    for (int i = 1; i <= 5; i++) begin
      #1;
      vectors++;
      if ({stall, mul_op} !== 4'b1111) begin miscompares++; $display("FAIL b2b_wait cyc%0d got stall=%b mul_op=%b want 1/111", i, stall, mul_op); end
      tick();
    end
    #1;
    vectors++; if ({stall, mul_op} !== 4'b0000) begin miscompares++; $display("FAIL b2b_reissue got stall=%b mul_op=%b want 0/000", stall, mul_op); end
    tick();
    req_valid = 1'b0;
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_busy got %b want 1", busy); end
    repeat (5) tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b want 0", busy); end
  endtask

  task automatic test_div_mflo();
    req_valid = 1'b1; req_op = OP_DIV; opa = 32'd100; opb = 32'd7;
    #1;
    vectors++; if (mul_op !== 3'b011) begin miscompares++; $display("FAIL div_issue_mul_op got %b want 011", mul_op); end
    tick();
    req_op = OP_MFLO;
    for (int i = 1; i <= 10; i++) begin
      #1;
      vectors++;
      if (stall !== 1'b1) begin miscompares++; $display("FAIL div_mflo_stall cyc%0d got %b want 1", i, stall); end
      tick();
    end
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL div_mflo_release got %b want 0", stall); end
    vectors++; if (hilo_sel !== 1'b0) begin miscompares++; $display("FAIL div_mflo_hilo_sel got %b want 0", hilo_sel); end
    vectors++; if (rd_val !== 32'd14) begin miscompares++; $display("FAIL div_quotient got %0d want 14", rd_val); end
    vectors++; if ({mul_op, mthilo} !== 5'b11111) begin miscompares++; $display("FAIL div_mflo_ctrl got %b want 11111", {mul_op, mthilo}); end
    tick();
    req_valid = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL div_mflo_no_run got %b want 0", busy); end
  endtask

  task automatic test_mthi_mfhi();
    req_valid = 1'b1; req_op = OP_MTHI; opa = 32'hDEAD_BEEF;
    #1;
    vectors++; if (mthilo !== 2'b01) begin miscompares++; $display("FAIL mthi_mthilo got %b want 01", mthilo); end
    vectors++; if (mul_op !== 3'b111) begin miscompares++; $display("FAIL mthi_mul_op got %b want 111", mul_op); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mthi_stall got %b want 0", stall); end
    tick();
    req_op = OP_MFHI;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mthi_busy got %b want 0", busy); end
    vectors++; if ({stall, hilo_sel} !== 2'b01) begin miscompares++; $display("FAIL mfhi_proceed got stall=%b hilo_sel=%b want 0/1", stall, hilo_sel); end
    vectors++; if (rd_val !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mfhi_value got %h want deadbeef", rd_val); end
    vectors++; if (mthilo !== 2'b11) begin miscompares++; $display("FAIL mfhi_mthilo got %b want 11", mthilo); end
    tick();
    req_op = OP_MTLO; opa = 32'h0000_1234;
    #1;
    vectors++; if (mthilo !== 2'b00) begin miscompares++; $display("FAIL mtlo_mthilo got %b want 00", mthilo); end
    tick();
    req_op = OP_MFLO;
    #1;
    vectors++; if (rd_val !== 32'h0000_1234) begin miscompares++; $display("FAIL mflo_value got %h want 00001234", rd_val); end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_flush();
    req_valid = 1'b1; req_op = OP_MULTU; opa = 32'd3; opb = 32'd5;
    tick();
    flush = 1'b1; req_op = OP_DIV; opa = 32'd9; opb = 32'd3;
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_stall got %b want 0", stall); end
    vectors++; if (mul_op !== 3'b111) begin miscompares++; $display("FAIL flush_mul_op got %b want 111", mul_op); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy got %b want 1", busy); end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    for (int i = 2; i <= 6; i++) begin
      #1;
      vectors++;
      if (busy !== (i <= 5)) begin miscompares++; $display("FAIL flush_run cyc%0d got %b want %b", i, busy, (i <= 5)); end
      if (i < 6) tick();
    end
    req_valid = 1'b1; req_op = OP_MFLO;
    #1;
    vectors++; if (rd_val !== 32'd15) begin miscompares++; $display("FAIL flush_multu_result got %0d want 15", rd_val); end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_op = OP_DIV; opa = 32'd50; opb = 32'd5;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    req_valid = 1'b1;
    #1;
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre_stall got %b want 1", stall); end
    reset = 1'b1;
    tick();
    reset = 1'b0; req_op = OP_MULT; opa = 32'd2; opb = 32'd3;
    #1;
    vectors++; if ({busy, stall} !== 2'b00) begin miscompares++; $display("FAIL rst_mid_release got busy=%b stall=%b want 0/0", busy, stall); end
    vectors++; if (mul_op !== 3'b001) begin miscompares++; $display("FAIL rst_mid_mult_issue got %b want 001", mul_op); end
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      #1;
      vectors++;
      if (busy !== (i <= 5)) begin miscompares++; $display("FAIL rst_mid_mult_busy cyc%0d got %b want %b", i, busy, (i <= 5)); end
      tick();
    end
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL rst_mid_sync_err got %b want 0", sync_err); end
  endtask

  task automatic test_sync_err();
    req_valid = 1'b1; req_op = OP_MULTU; opa = 32'd1; opb = 32'd1;
    tick();
    req_valid = 1'b0; force_idle = 1'b1;
    #1;
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL sync_err_pre got %b want 0", sync_err); end
    tick();
    force_idle = 1'b0;
    #1;
    vectors++; if (sync_err !== 1'b1) begin miscompares++; $display("FAIL sync_err_set got %b want 1", sync_err); end
    repeat (6) tick();
    vectors++; if ({sync_err, busy} !== 2'b10) begin miscompares++; $display("FAIL sync_err_sticky got err=%b busy=%b want 1/0", sync_err, busy); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL sync_err_clear got %b want 0", sync_err); end
    tick();
    vectors++; if (sync_err !== 1'b0) begin miscompares++; $display("FAIL sync_err_stays_clear got %b want 0", sync_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div_mflo();
    test_mthi_mfhi();
    test_flush();
    test_reset_mid();
    test_sync_err();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Sequences the shared HI/LO multiply/divide unit from the E stage of the 5-stage MIPS pipeline.
- Decodes each muldiv-class instruction (mult/multu/div/divu/mthi/mtlo/mfhi/mflo) into the unit's `MulOp`/`MTHILO` controls.
- Tracks the unit's occupancy with its own latency counter and raises `stall` to freeze D/E while a prior operation is still in flight.
- Cross-checks its model against the unit's `busy` output and flags any divergence.

Parameters:
- MUL_LAT, 5, cycles the unit stays busy after a mult/multu issue edge.
- DIV_LAT, 10, cycles the unit stays busy after a div/divu issue edge.
- CNT_W, 4, latency counter width; must hold max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  E-stage instruction is muldiv class
- req_op  in  3  000 multu, 001 mult, 010 divu, 011 div, 100 mthi, 101 mtlo, 110 mfhi, 111 mflo
- flush  in  1  E-stage instruction is killed this cycle (bubble/exception)
- unit_busy  in  1  busy output of the multiply/divide unit
- mul_op  out  3  to unit MulOp; 3'b111 = no operation
- mthilo  out  2  to unit MTHILO; 2'b00 write LO, 2'b01 write HI, 2'b11 = none
- hilo_sel  out  1  E-stage read mux: 1 = HI, 0 = LO (valid for mfhi/mflo)
- stall  out  1  freeze D and E stages and insert a bubble into M
- busy  out  1  controller's model of unit occupancy
- sync_err  out  1  sticky: model and unit_busy disagreed

Behaviour:
- Define `go = req_valid & ~flush & ~stall`.
- State machine has three states: IDLE, RUN_MUL, RUN_DIV. Register `cnt` is CNT_W bits wide.
- Reset values: state IDLE, cnt 0, sync_err 0.
  - With reset held and req_valid=0: mul_op 3'b111, mthilo 2'b11, stall 0, busy 0, hilo_sel 0.
- `busy` = (state != IDLE).
- `stall` = req_valid & ~flush & busy.
  - Every muldiv-class op waits, including mfhi/mflo and mthi/mtlo. This preserves HI/LO ordering.
- mul_op, combinational:
  - Equals req_op when go and req_op[2]=0; otherwise 3'b111.
- mthilo, combinational:
  - 2'b01 when go and req_op=100 (mthi).
  - 2'b00 when go and req_op=101 (mtlo).
  - 2'b11 otherwise.
- hilo_sel = (req_op == 110).
  - The E-stage mux uses it only on the cycle mf* proceeds (stall=0).
- Transitions:
  - IDLE -> RUN_MUL on go with op 000/001; cnt <= MUL_LAT.
  - IDLE -> RUN_DIV on go with op 010/011; cnt <= DIV_LAT.
  - mt*/mf* in IDLE: single cycle, no state change.
  - RUN_*: cnt <= cnt-1 every cycle. When cnt==1, next state is IDLE.
  - Result: busy is high for exactly MUL_LAT/DIV_LAT cycles after the issue edge, matching the unit's busy.
- Back-to-back:
  - The instruction after an issue sees busy=1 on the next cycle and stalls.
  - On the cycle cnt reaches 0, state is IDLE, stall drops, and a new op may issue the same cycle.
- flush has priority over everything else:
  - Flushed requests never issue, never stall, and never drive mul_op/mthilo.
  - flush does NOT abort an in-flight operation; the counter keeps running.
- req_valid=0: stall=0. The counter still runs; a non-muldiv instruction proceeds freely.
- sync_err is set on any cycle where busy != unit_busy. Only reset clears it.
- Reset mid-operation:
  - State returns to IDLE and cnt to 0.
  - stall drops the cycle after reset is sampled.
  - The unit is reset on the same edge.
- The counter never wraps: decrement happens only in RUN_* with cnt>=1.

Decomposition:
- Shared package/header holds:
  - req_op encodings (OP_MULTU..OP_MFLO).
  - MulOp values, including MULOP_NONE=3'b111.
  - MTHILO values (MT_LO, MT_HI, MT_NONE=2'b11).
  - MUL_LAT/DIV_LAT defaults, so the unit and the controller share one source.
- The FSM, counter and decode are a single module.
- A sub-module is optional: muldiv_decode, a combinational req_op -> class/mul_op/mthilo decoder reusable by the D-stage hazard unit.

Test Plan:
- Issue a single mult (req_op=001) from IDLE:
  - mul_op=001 on the issue cycle; busy high for exactly 5 cycles; sync_err stays 0 with the real unit attached.
- Issue div (011), then mflo on the next cycle:
  - stall=1 for 10 cycles, then mflo proceeds with hilo_sel=0 and the correct quotient on LO.
- Issue mthi while idle:
  - mthilo=01, mul_op=111, no stall, busy stays 0.
  - A following mfhi proceeds the next cycle with hilo_sel=1.
- Issue multu, then assert flush together with req_valid for a div during the run:
  - No stall on the flushed cycle, mul_op=111, and the multu still completes after 5 cycles.
- Assert reset 3 cycles into a div:
  - busy=0 and stall=0 the next cycle.
  - A mult issued immediately after reset is accepted with cnt=5.
- Force unit_busy=0 while the model is in RUN_MUL:
  - sync_err=1 the following cycle and stays 1 until reset.
